// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch stage for the RISC-V core.
// Optional misaligned-target fault: define PC_MISALIGN_FAULT_EN.
module pc_fetch_unit #(
    parameter int unsigned                DataWidth    = 32,
    parameter int unsigned                AddressWidth = 10,
    parameter logic [AddressWidth-1:0]    ResetPc      = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    pc_src_mux_i,
    input  logic [AddressWidth-1:0] pc_target_i,
    input  logic                    retire_i,
    output logic                    imem_req_o,
    output logic [AddressWidth-1:0] imem_addr_o,
    input  logic                    imem_ready_i,
    input  logic                    imem_rvalid_i,
    input  logic [DataWidth-1:0]    imem_rdata_i,
    output logic [DataWidth-1:0]    instr_o,
    output logic                    instr_valid_o,
    output logic [AddressWidth-1:0] pc_o,
    output logic [AddressWidth-1:0] pc_plus4_o,
    output logic [31:0]             instret_o,
    output logic                    fault_o
);

    localparam int unsigned InstretWidth = 32;

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StHold,
        StFault
    } state_e;

    state_e                   state_q, state_d;
    logic [AddressWidth-1:0]  pc_q, pc_d;
    logic [DataWidth-1:0]     instr_q, instr_d;
    logic                     instr_valid_q, instr_valid_d;
    logic [InstretWidth-1:0]  instret_q, instret_d;
    logic [AddressWidth-1:0]  pc_plus4;
    logic [AddressWidth-1:0]  sel_pc;
`ifdef PC_MISALIGN_FAULT_EN
    logic                     fault_q, fault_d;
`endif

    assign pc_plus4 = pc_q + AddressWidth'(4);

    // Request is gated by rst_i so it stays low throughout reset.
    assign imem_req_o    = (state_q == StFetch) && !rst_i;
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_plus4;
    assign instr_o       = instr_q;
    assign instr_valid_o = instr_valid_q;
    assign instret_o     = instret_q;
`ifdef PC_MISALIGN_FAULT_EN
    assign fault_o       = fault_q;
`else
    assign fault_o       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StFetch;
            pc_q          <= ResetPc;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            instret_q     <= '0;
`ifdef PC_MISALIGN_FAULT_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            instret_q     <= instret_d;
`ifdef PC_MISALIGN_FAULT_EN
            fault_q       <= fault_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        instret_d     = instret_q;
`ifdef PC_MISALIGN_FAULT_EN
        fault_d       = fault_q;
        sel_pc        = pc_src_mux_i ? pc_target_i : pc_plus4;
`else
        sel_pc        = pc_src_mux_i ? pc_target_i : pc_plus4;
        sel_pc[1:0]   = 2'b00;
`endif

        unique case (state_q)
            StFetch: begin
                if (imem_ready_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid_i) begin
                    instr_d       = imem_rdata_i;
                    instr_valid_d = 1'b1;
                    state_d       = StHold;
                end
            end
            StHold: begin
                if (retire_i) begin
                    instr_valid_d = 1'b0;
                    instret_d     = instret_q + InstretWidth'(1);
                    pc_d          = sel_pc;
                    state_d       = StFetch;
`ifdef PC_MISALIGN_FAULT_EN
                    if (sel_pc[1:0] != 2'b00) begin
                        state_d = StFault;
                        fault_d = 1'b1;
                    end
`endif
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

endmodule
